apb_master_bridge_mp: RTL and testbench

//  Parametrised APB master bridge: the next generation of the two-slave bridge.

---
 rtl/apb_mp_pkg.sv | 21 ++
 rtl/apb_addr_decode.sv | 32 +++
 rtl/apb_master_bridge_mp.sv | 197 +++++++++++++++++++
 tb/tb_apb_master_bridge_mp.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mp_pkg.sv
// Shared types and sizing helpers for the multi-slave APB master bridge.
package apb_mp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } apb_state_e;

    // Width of the slave-select field at the top of the address.
    function automatic int unsigned sel_w(input int unsigned num_slaves);
        return (num_slaves < 2) ? 1 : $clog2(num_slaves);
    endfunction

    // Width of the wait-state counter; a zero timeout still needs one bit.
    function automatic int unsigned cnt_w(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Address decoder: top select bits of the address to slave index, one-hot select
// and a decode error when the index names a slave that does not exist.
module apb_addr_decode
    import apb_mp_pkg::*;
#(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned NUM_SLAVES = 2,
    localparam int unsigned SEL_W     = sel_w(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [SEL_W-1:0]      idx,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  decode_err
);

    logic unused_addr;

    assign idx         = addr[ADDR_W-1 -: SEL_W];
    assign unused_addr = ^addr[ADDR_W-SEL_W-1:0];

    always_comb begin
        sel        = '0;
        decode_err = 1'b1;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (idx == SEL_W'(i)) begin
                sel[i]     = 1'b1;
                decode_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_master_bridge_mp.sv
// APB master bridge: one valid/ready request at a time, full SETUP/ACCESS transfer to
// one of NUM_SLAVES slaves, one-cycle response with read data and error causes.
module apb_master_bridge_mp
    import apb_mp_pkg::*;
#(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic                         rsp_timeout,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic [ADDR_W-1:0]            PADDR,
    output logic                         PWRITE,
    output logic [DATA_W-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam int unsigned      SEL_W    = sel_w(NUM_SLAVES);
    localparam int unsigned      CNT_W    = cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    apb_state_e state_q, state_d;

    logic [SEL_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_W-1:0]     pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic [SEL_W-1:0]      dec_idx;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_err;

    logic                  sel_ready;
    logic                  sel_slverr;
    logic [DATA_W-1:0]     sel_rdata;

    apb_addr_decode #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_decode (
        .addr       (req_addr),
        .idx        (dec_idx),
        .sel        (dec_sel),
        .decode_err (dec_err)
    );

    assign req_ready = (state_q == StIdle) && !PRESET;

    // Only the addressed slave's return signals are ever looked at.
    always_comb begin
        sel_ready  = 1'b0;
        sel_slverr = 1'b0;
        sel_rdata  = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_ready  = PREADY[i];
                sel_slverr = PSLVERR[i];
                sel_rdata  = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    if (dec_err) begin
                        // Nonexistent slave: answer immediately, leave the bus untouched.
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = StSetup;
                        idx_d    = dec_idx;
                        cnt_d    = '0;
                        psel_d   = dec_sel;
                        paddr_d  = req_addr;
                        pwrite_d = req_write;
                        if (req_write) begin
                            pwdata_d = req_wdata;
                        end
                    end
                end
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
            end
            StAccess: begin
                if (sel_ready) begin
                    state_d     = StResp;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_slverr;
                    if (!pwrite_q && !sel_slverr) begin
                        rsp_rdata_d = sel_rdata;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d       = StResp;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            cnt_q         <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

    psel_onehot_a: assert property (@(posedge PCLK) disable iff (PRESET) $onehot0(PSEL));
    penable_sel_a: assert property (@(posedge PCLK) disable iff (PRESET) PENABLE |-> |PSEL);

endmodule

// File: tb/tb_apb_master_bridge_mp.sv
// Scoreboard bench for apb_master_bridge_mp with three slaves and a timeout of four.
module tb_apb_master_bridge_mp;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NS     = 3;
    localparam int unsigned TO     = 4;

    logic              PCLK = 1'b0;
    logic              PRESET = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [NS-1:0]     PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [NS*DATA_W-1:0] PRDATA;
    logic [NS-1:0]     PREADY;
    logic [NS-1:0]     PSLVERR;

    always #5 PCLK = ~PCLK;

    apb_master_bridge_mp #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_SLAVES (NS),
        .TIMEOUT    (TO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    typedef struct {
        bit           wr;
        logic [8:0]   addr;
        logic [7:0]   wdata;
        logic [2:0]   psel;
        logic [7:0]   rdata;
        bit           err;
        bit           to;
        int           lat;
        int           acc;
        string        name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit apb_chk_en = 1'b1;
    bit prev_sel = 1'b0;

    // Slave models: selected slave waits waits[i] ACCESS cycles; unselected ones
    // drive ready and error high so a wrongly indexed bridge gets caught.
    int         waits[NS];
    bit         erdy[NS];
    bit         ewait[NS];
    logic [7:0] rd[NS];
    int         wcnt;

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(posedge PCLK) begin
        if (PRESET || !((|PSEL) && PENABLE)) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    always_comb begin
        PREADY  = '0;
        PSLVERR = '0;
        PRDATA  = '0;
        for (int i = 0; i < NS; i++) begin
            if (PSEL[i] && PENABLE) begin
                PREADY[i]  = (wcnt >= waits[i]);
                PSLVERR[i] = (wcnt >= waits[i]) ? erdy[i] : ewait[i];
            end else begin
                PREADY[i]  = 1'b1;
                PSLVERR[i] = 1'b1;
            end
            PRDATA[i*8 +: 8] = rd[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: checks the APB bus against the outstanding request and pops the
    // scoreboard on every response strobe.
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (apb_chk_en && (PSEL != 0)) begin
                if (q.size() == 0) begin
                    check("apb_without_request", 32'(PSEL), 32'd0);
                end else begin
                    check({q[0].name, "_psel"}, 32'(PSEL), 32'(q[0].psel));
                    check({q[0].name, "_paddr"}, 32'(PADDR), 32'(q[0].addr));
                    check({q[0].name, "_pwrite"}, 32'(PWRITE), 32'(q[0].wr));
                    if (q[0].wr) check({q[0].name, "_pwdata"}, 32'(PWDATA), 32'(q[0].wdata));
                end
            end
            if (PENABLE) check("access_after_setup", 32'(prev_sel), 32'd1);
            if (rsp_valid) begin
                check("ready_low_in_resp", 32'(req_ready), 32'd0);
                if (q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check({mon_e.name, "_rdata"}, 32'(rsp_rdata), 32'(mon_e.rdata));
                    check({mon_e.name, "_err"}, 32'(rsp_err), 32'(mon_e.err));
                    check({mon_e.name, "_timeout"}, 32'(rsp_timeout), 32'(mon_e.to));
                    check({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
                end
            end
        end
        prev_sel = |PSEL;
    end

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(negedge PCLK);
            guard++;
        end
        if (q.size() != 0) check({name, "_drain"}, 32'(q.size()), 32'd0);
    endtask

    task automatic do_req(input string name, input bit wr, input logic [8:0] addr,
                          input logic [7:0] wdata, input int sl, input int w, input bit er,
                          input bit ew, input logic [7:0] rdv, input logic [2:0] psel,
                          input logic [7:0] rdata, input bit err, input bit to, input int lat);
        exp_t e;
        int guard;
        wait_drain(name);
        if (sl >= 0) begin
            waits[sl] = w;
            erdy[sl]  = er;
            ewait[sl] = ew;
            rd[sl]    = rdv;
        end
        @(negedge PCLK);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge PCLK);
            guard++;
        end
        if (!req_ready) begin
            check({name, "_accept"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge PCLK);
        #1;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.psel = psel; e.rdata = rdata;
        e.err = err; e.to = to; e.lat = lat; e.acc = cyc; e.name = name;
        q.push_back(e);
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            waits[i] = 0;
            erdy[i]  = 1'b0;
            ewait[i] = 1'b0;
            rd[i]    = 8'h00;
        end

        repeat (3) @(negedge PCLK);
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_paddr", 32'(PADDR), 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_pwdata", 32'(PWDATA), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_ready_held", 32'(req_ready), 32'd0);
        PRESET = 1'b0;
        #1;
        check("rst_ready_released", 32'(req_ready), 32'd1);

        //     name               wr addr    wdata sl  w  er ew rdv    psel    rdata  err to lat
        do_req("wr_s0",           1, 9'h004, 8'h5A, 0, 0, 0, 0, 8'h11, 3'b001, 8'h00, 0, 0, 3);
        do_req("rd_s1_wait2",     0, 9'h0A0, 8'h00, 1, 2, 0, 0, 8'hC3, 3'b010, 8'hC3, 0, 0, 5);
        do_req("rd_decerr",       0, 9'h1F0, 8'h00, -1, 0, 0, 0, 8'h00, 3'b000, 8'h00, 1, 0, 1);
        do_req("wr_s2_timeout",   1, 9'h100, 8'h77, 2, 99, 0, 0, 8'h99, 3'b100, 8'h00, 1, 1, 6);
        do_req("rd_s1_slverr",    0, 9'h0A5, 8'h00, 1, 1, 1, 1, 8'h5A, 3'b010, 8'h00, 1, 0, 4);
        do_req("rd_s1_waiterr",   0, 9'h0B0, 8'h00, 1, 2, 0, 1, 8'h3C, 3'b010, 8'h3C, 0, 0, 5);
        do_req("rd_s0",           0, 9'h010, 8'h00, 0, 0, 0, 0, 8'h11, 3'b001, 8'h11, 0, 0, 3);
        do_req("rd_s2_wait3",     0, 9'h120, 8'h00, 2, 3, 0, 0, 8'hE7, 3'b100, 8'hE7, 0, 0, 6);
        do_req("wr_s2_slverr",    1, 9'h144, 8'h96, 2, 0, 1, 0, 8'hE7, 3'b100, 8'h00, 1, 0, 3);
        do_req("wr_decerr",       1, 9'h1C4, 8'hFF, -1, 0, 0, 0, 8'h00, 3'b000, 8'h00, 1, 0, 1);

        // Reset in the middle of an ACCESS phase: transfer vanishes without a response.
        wait_drain("rst_mid");
        waits[0] = 99;
        erdy[0]  = 1'b0;
        ewait[0] = 1'b0;
        apb_chk_en = 1'b0;
        @(negedge PCLK);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 9'h008;
        for (int g = 0; g < 50 && !req_ready; g++) @(negedge PCLK);
        check("rst_mid_accept", 32'(req_ready), 32'd1);
        @(posedge PCLK);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        check("rst_mid_in_access", 32'(PENABLE), 32'd1);
        PRESET = 1'b1;
        #1;
        check("rst_mid_ready_low", 32'(req_ready), 32'd0);
        @(negedge PCLK);
        check("rst_mid_psel", 32'(PSEL), 32'd0);
        check("rst_mid_penable", 32'(PENABLE), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_paddr", 32'(PADDR), 32'd0);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        apb_chk_en = 1'b1;

        do_req("wr_s0_after_rst", 1, 9'h004, 8'hA5, 0, 0, 0, 0, 8'h11, 3'b001, 8'h00, 0, 0, 3);

        wait_drain("final");
        repeat (3) @(negedge PCLK);
        check("final_queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
